// File: rtl/bus_timer.sv
// Memory-mapped prescaled down-counting timer with sticky expiry flag and level interrupt.
// Optional PWM output and DUTY register are built only when TIMER_PWM_EN is defined.
module bus_timer #(
    parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
    input  logic        clk_bus,
    input  logic        rst_bus,
    input  logic [15:0] bus_addr,
    input  logic [15:0] bus_wdata,
    input  logic        bus_write,
    output logic [15:0] bus_rdata,
    output logic        irq
`ifdef TIMER_PWM_EN
    ,
    output logic        pwm_out
`endif
);

    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_PRESC  = 3'd1;
    localparam logic [2:0] OFF_RELOAD = 3'd2;
    localparam logic [2:0] OFF_COUNT  = 3'd3;
    localparam logic [2:0] OFF_STATUS = 3'd4;
    localparam logic [2:0] OFF_DUTY   = 3'd5;

    logic        en_q, en_d;
    logic        auto_q, auto_d;
    logic        irq_en_q, irq_en_d;
    logic        exp_q, exp_d;
    logic [15:0] presc_q, presc_d;
    logic [15:0] reload_q, reload_d;
    logic [15:0] count_q, count_d;
    logic [15:0] pcnt_q, pcnt_d;
`ifdef TIMER_PWM_EN
    logic [15:0] duty_q, duty_d;
    logic        pwm_q, pwm_d;
`endif

    logic       hit;
    logic [2:0] off;
    logic       wr_ctrl, wr_presc, wr_reload, wr_count, wr_status;
    logic       tick, tick_eff, expire;

    always_comb begin
        hit       = (bus_addr[15:3] == BASE_ADDR[15:3]);
        off       = bus_addr[2:0];
        wr_ctrl   = bus_write && hit && (off == OFF_CTRL);
        wr_presc  = bus_write && hit && (off == OFF_PRESC);
        wr_reload = bus_write && hit && (off == OFF_RELOAD);
        wr_count  = bus_write && hit && (off == OFF_COUNT);
        wr_status = bus_write && hit && (off == OFF_STATUS);

        // A COUNT write on a tick edge swallows that tick entirely.
        tick     = en_q && (pcnt_q == presc_q);
        tick_eff = tick && !wr_count;
        expire   = tick_eff && (count_q == 16'd0);

        en_d     = en_q;
        auto_d   = auto_q;
        irq_en_d = irq_en_q;
        exp_d    = exp_q;
        presc_d  = presc_q;
        reload_d = reload_q;
        count_d  = count_q;

        if (tick_eff) begin
            if (count_q != 16'd0) begin
                count_d = count_q - 16'd1;
            end else if (auto_q) begin
                count_d = reload_q;
            end else begin
                en_d = 1'b0;
            end
        end

        if (wr_status && bus_wdata[0]) exp_d = 1'b0;
        if (expire) exp_d = 1'b1;

        if (wr_ctrl) begin
            en_d     = bus_wdata[0];
            auto_d   = bus_wdata[1];
            irq_en_d = bus_wdata[2];
        end
        if (wr_presc)  presc_d  = bus_wdata;
        if (wr_reload) reload_d = bus_wdata;
        if (wr_count)  count_d  = bus_wdata;

        if (!en_d || tick || wr_count || (wr_ctrl && bus_wdata[0] && !en_q)) begin
            pcnt_d = 16'd0;
        end else begin
            pcnt_d = pcnt_q + 16'd1;
        end

`ifdef TIMER_PWM_EN
        duty_d = duty_q;
        if (bus_write && hit && (off == OFF_DUTY)) duty_d = bus_wdata;
        pwm_d = en_q && (count_q < duty_q);
`endif
    end

    always_comb begin
        bus_rdata = 16'd0;
        if (hit) begin
            case (off)
                OFF_CTRL:   bus_rdata = {13'd0, irq_en_q, auto_q, en_q};
                OFF_PRESC:  bus_rdata = presc_q;
                OFF_RELOAD: bus_rdata = reload_q;
                OFF_COUNT:  bus_rdata = count_q;
                OFF_STATUS: bus_rdata = {15'd0, exp_q};
`ifdef TIMER_PWM_EN
                OFF_DUTY:   bus_rdata = duty_q;
`endif
                default:    bus_rdata = 16'd0;
            endcase
        end
    end

    always_ff @(posedge clk_bus) begin
        if (rst_bus) begin
            en_q     <= 1'b0;
            auto_q   <= 1'b0;
            irq_en_q <= 1'b0;
            exp_q    <= 1'b0;
            presc_q  <= 16'd0;
            reload_q <= 16'd0;
            count_q  <= 16'd0;
            pcnt_q   <= 16'd0;
`ifdef TIMER_PWM_EN
            duty_q   <= 16'd0;
            pwm_q    <= 1'b0;
`endif
        end else begin
            en_q     <= en_d;
            auto_q   <= auto_d;
            irq_en_q <= irq_en_d;
            exp_q    <= exp_d;
            presc_q  <= presc_d;
            reload_q <= reload_d;
            count_q  <= count_d;
            pcnt_q   <= pcnt_d;
`ifdef TIMER_PWM_EN
            duty_q   <= duty_d;
            pwm_q    <= pwm_d;
`endif
        end
    end

    assign irq = exp_q && irq_en_q;
`ifdef TIMER_PWM_EN
    assign pwm_out = pwm_q;
`endif

endmodule

// File: tb/tb_bus_timer.sv
// Scoreboard bench for bus_timer: stimulus pushes expected values, a negedge monitor compares.
// Exercises the PWM path too when TIMER_PWM_EN is defined.
module tb_bus_timer;

    localparam logic [15:0] BASE = 16'hFF00;

    logic        clk_bus = 1'b0;
    logic        rst_bus;
    logic [15:0] bus_addr;
    logic [15:0] bus_wdata;
    logic        bus_write;
    logic [15:0] bus_rdata;
    logic        irq;
`ifdef TIMER_PWM_EN
    logic        pwm_out;
`endif

    bus_timer #(.BASE_ADDR(BASE)) dut (
        .clk_bus   (clk_bus),
        .rst_bus   (rst_bus),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_write (bus_write),
        .bus_rdata (bus_rdata),
        .irq       (irq)
`ifdef TIMER_PWM_EN
        ,
        .pwm_out   (pwm_out)
`endif
    );

    always #5 clk_bus = ~clk_bus;

    typedef struct {
        string       name;
        int          kind;      // 0 read data, 1 irq, 2 pwm_out
        logic [15:0] expv;
    } sb_entry_t;

    sb_entry_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;

    always @(negedge clk_bus) begin
        while (sb.size() > 0) begin
            sb_entry_t e;
            logic [15:0] act;
            e = sb.pop_front();
            case (e.kind)
                0: act = bus_rdata;
                1: act = {15'd0, irq};
`ifdef TIMER_PWM_EN
                2: act = {15'd0, pwm_out};
`endif
                default: act = 16'hDEAD;
            endcase
            n_tests++;
            if (act !== e.expv) begin
                n_fail++;
                $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", e.name, act, e.expv, $time);
            end
        end
    end

    // Every task starts 1 ns after an edge and returns 1 ns after the next one.
    task automatic wr(input logic [2:0] off, input logic [15:0] data);
        bus_addr  = BASE + {13'd0, off};
        bus_wdata = data;
        bus_write = 1'b1;
        @(posedge clk_bus);
        #1;
        bus_write = 1'b0;
        bus_wdata = 16'd0;
    endtask

    task automatic push_wait(input string name, input int kind, input logic [15:0] expv);
        sb_entry_t e;
        e.name = name;
        e.kind = kind;
        e.expv = expv;
        sb.push_back(e);
        @(negedge clk_bus);
        @(posedge clk_bus);
        #1;
    endtask

    task automatic chk_addr(input string name, input logic [15:0] addr, input logic [15:0] expv);
        bus_addr = addr;
        push_wait(name, 0, expv);
    endtask

    task automatic chk_rd(input string name, input logic [2:0] off, input logic [15:0] expv);
        chk_addr(name, BASE + {13'd0, off}, expv);
    endtask

    task automatic chk_irq(input string name, input logic expv);
        push_wait(name, 1, {15'd0, expv});
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_bus);
        #1;
    endtask

    initial begin
        rst_bus   = 1'b1;
        bus_addr  = 16'h0000;
        bus_wdata = 16'd0;
        bus_write = 1'b0;
        @(posedge clk_bus);
        #1;
        chk_addr("rd_outside_in_reset", 16'h0000, 16'd0);
        rst_bus = 1'b0;

        // Reset state
        for (int i = 0; i < 8; i++) chk_rd($sformatf("reset_off%0d", i), 3'(i), 16'd0);
        chk_addr("reset_outside", 16'h0000, 16'd0);
        chk_irq("reset_irq", 1'b0);

        // Offset 5 and reserved offsets
        wr(3'd5, 16'hFFFF);
`ifdef TIMER_PWM_EN
        chk_rd("duty_rw", 3'd5, 16'hFFFF);
`else
        chk_rd("off5_nopwm", 3'd5, 16'd0);
`endif
        wr(3'd6, 16'hFFFF);
        wr(3'd7, 16'hFFFF);
        chk_rd("reserved6", 3'd6, 16'd0);
        chk_rd("reserved7", 3'd7, 16'd0);

        // Writes just outside the window must not land
        bus_addr = 16'hFF0B; bus_wdata = 16'h1234; bus_write = 1'b1;
        @(posedge clk_bus); #1; bus_write = 1'b0;
        chk_rd("outside_write_ignored", 3'd3, 16'd0);
        chk_addr("rd_next_window", 16'hFF08, 16'd0);
        wr(3'd2, 16'hABCD);
        chk_rd("reload_rw", 3'd2, 16'hABCD);
        chk_addr("rd_below_window", 16'hFEFA, 16'd0);

        // One-shot: PRESC=0, COUNT=5, CTRL=EN|IRQ_EN
        wr(3'd1, 16'd0);
        wr(3'd3, 16'd5);
        wr(3'd0, 16'h0005);
        for (int k = 0; k < 6; k++) chk_irq($sformatf("oneshot_irq_low_e%0d", k), 1'b0);
        chk_irq("oneshot_irq_rise_e6", 1'b1);
        chk_rd("oneshot_ctrl_en_cleared", 3'd0, 16'h0004);
        chk_rd("oneshot_count_zero", 3'd3, 16'd0);
        wr(3'd4, 16'h0000);
        chk_rd("status_write0_noeffect", 3'd4, 16'h0001);
        wr(3'd4, 16'h0001);
        chk_irq("oneshot_irq_cleared", 1'b0);
        chk_rd("oneshot_stays_zero", 3'd3, 16'd0);

        // Periodic: PRESC=3, RELOAD=2, COUNT=2, CTRL=EN|AUTO; expiries at edges 12, 24, 36
        wr(3'd1, 16'd3);
        wr(3'd2, 16'd2);
        wr(3'd3, 16'd2);
        wr(3'd0, 16'h0003);
        for (int k = 0; k < 12; k++) chk_rd($sformatf("per_exp_low_e%0d", k), 3'd4, 16'd0);
        chk_rd("per_exp_set_e12", 3'd4, 16'd1);
        chk_rd("per_count_reloaded_e13", 3'd3, 16'd2);
        wr(3'd4, 16'h0001);
        chk_rd("per_exp_cleared_e15", 3'd4, 16'd0);
        for (int k = 16; k < 24; k++) chk_rd($sformatf("per2_exp_low_e%0d", k), 3'd4, 16'd0);
        chk_rd("per2_exp_set_e24", 3'd4, 16'd1);

        // Clear-write lands on the expiry edge 36: set wins
        idle(10);
        wr(3'd4, 16'h0001);
        chk_rd("clear_vs_expiry", 3'd4, 16'd1);
        chk_rd("per_count_reload_e37", 3'd3, 16'd2);

        // COUNT write on tick edge 40: write wins, next tick at 44
        idle(1);
        wr(3'd3, 16'd7);
        for (int k = 40; k < 44; k++) chk_rd($sformatf("cntwr_hold_e%0d", k), 3'd3, 16'd7);
        chk_rd("cntwr_next_tick_e44", 3'd3, 16'd6);

        // Reset mid-count with EXP still set and IRQ_EN on
        wr(3'd0, 16'h0000);
        wr(3'd1, 16'd0);
        wr(3'd3, 16'd100);
        wr(3'd0, 16'h0007);
        chk_rd("run_count_100", 3'd3, 16'd100);
        chk_irq("run_irq_high", 1'b1);
        rst_bus = 1'b1;
        @(posedge clk_bus);
        #1;
        rst_bus = 1'b0;
        chk_irq("rst_irq_low", 1'b0);
        for (int i = 0; i < 5; i++) chk_rd($sformatf("rst_mid_off%0d", i), 3'(i), 16'd0);
        idle(3);
        chk_rd("rst_no_ticks_count", 3'd3, 16'd0);
        chk_rd("rst_no_ticks_ctrl", 3'd0, 16'd0);

`ifdef TIMER_PWM_EN
        // PWM: COUNT cycles 9..0, high while COUNT<3
        wr(3'd1, 16'd0);
        wr(3'd2, 16'd9);
        wr(3'd5, 16'd3);
        wr(3'd3, 16'd9);
        wr(3'd0, 16'h0003);
        idle(1);
        for (int k = 1; k <= 20; k++)
            push_wait($sformatf("pwm_e%0d", k), 2, {15'd0, ((k - 1) % 10) >= 7});
`endif

        idle(2);
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
